lc_port_arbiter: RTL and testbench

- Shares the single lower-level-cache (LC) port between N_REQ L1 clients, e.g. L1I = client 0 and L1D = client 1.
- Grants client requests round-robin into a registered LC request stage.
- Tracks outstanding reads in an in-order ID FIFO and routes each LC read response back to the client that issued it.
- Sits between the L1 caches' lc_* interfaces and the L2/LC.

---
 rtl/lc_port_arbiter_if.sv | 55 +++++
 rtl/lc_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_lc_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc_port_arbiter_if.sv
// LC port arbiter bundle: client request/response
// lanes plus the single shared LC port.
interface lc_port_arbiter_if #(
  parameter int PADDR_BITS = 22,
  parameter int LINE_BITS  = 512,
  parameter int N_REQ      = 2
);
  logic [N_REQ-1:0]            req_valid_in;
  logic [N_REQ-1:0]            req_ready_out;
  logic [N_REQ*PADDR_BITS-1:0] req_addr_in;
  logic [N_REQ*LINE_BITS-1:0]  req_value_in;
  logic [N_REQ-1:0]            req_we_in;
  logic [N_REQ-1:0]            resp_valid_out;
  logic [N_REQ-1:0]            resp_ready_in;
  logic [PADDR_BITS-1:0]       resp_addr_out;
  logic [LINE_BITS-1:0]        resp_value_out;
  logic                        lc_valid_out;
  logic                        lc_ready_in;
  logic [PADDR_BITS-1:0]       lc_addr_out;
  logic [LINE_BITS-1:0]        lc_value_out;
  logic                        lc_we_out;
  logic                        lc_valid_in;
  logic                        lc_ready_out;
  logic [PADDR_BITS-1:0]       lc_addr_in;
  logic [LINE_BITS-1:0]        lc_value_in;
  logic                        err_unexpected_resp_out;

  modport slave (
    input  req_valid_in, req_addr_in,
    input  req_value_in, req_we_in,
    input  resp_ready_in,
    input  lc_ready_in, lc_valid_in,
    input  lc_addr_in, lc_value_in,
    output req_ready_out, resp_valid_out,
    output resp_addr_out, resp_value_out,
    output lc_valid_out, lc_addr_out,
    output lc_value_out, lc_we_out,
    output lc_ready_out,
    output err_unexpected_resp_out
  );

  modport master (
    output req_valid_in, req_addr_in,
    output req_value_in, req_we_in,
    output resp_ready_in,
    output lc_ready_in, lc_valid_in,
    output lc_addr_in, lc_value_in,
    input  req_ready_out, resp_valid_out,
    input  resp_addr_out, resp_value_out,
    input  lc_valid_out, lc_addr_out,
    input  lc_value_out, lc_we_out,
    input  lc_ready_out,
    input  err_unexpected_resp_out
  );
endinterface

// File: rtl/lc_port_arbiter.sv
// Round-robin arbiter sharing one LC port between
// L1 clients, with in-order read ID tracking.
module lc_port_arbiter #(
  parameter int PADDR_BITS  = 22,
  parameter int LINE_BITS   = 512,
  parameter int N_REQ       = 2,
  parameter int OUTSTANDING = 4
) (
  input logic             clk_in,
  input logic             rst_N_in,
  lc_port_arbiter_if.slave bus
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW  = (OUTSTANDING > 1) ?
                       $clog2(OUTSTANDING) : 1;
  localparam int CW  = $clog2(OUTSTANDING) + 1;
  localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);
  localparam logic [IDW-1:0] LAST = IDW'(N_REQ - 1);

  logic                  stg_valid;
  logic [PADDR_BITS-1:0] stg_addr;
  logic [LINE_BITS-1:0]  stg_value;
  logic                  stg_we;
  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        fifo [OUTSTANDING];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  err_q;

  logic                  slot_free;
  logic [N_REQ-1:0]      eligible;
  logic [N_REQ-1:0]      grant;
  logic [IDW-1:0]        gnt_id;
  logic                  gnt_any;
  logic                  push;
  logic                  pop;
  logic [IDW-1:0]        head;
  logic                  fifo_empty;
  logic [N_REQ-1:0]      resp_valid;
  logic                  lc_ready;

  assign slot_free  = !stg_valid || bus.lc_ready_in;
  assign fifo_empty = (count == '0);
  assign head       = fifo[rd_ptr];

  // Reads need a free ID slot; writebacks never do.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = bus.req_valid_in[i] &&
                    (bus.req_we_in[i] || count != FULL);
    end
  end

  // Scan from the round-robin pointer with wrap.
  always_comb begin
    int s;
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    s       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(rr_ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (!gnt_any && rst_N_in && slot_free &&
          eligible[s]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(s);
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  // Route the LC response to the oldest reader.
  always_comb begin
    resp_valid = '0;
    lc_ready   = 1'b1;
    if (!fifo_empty) begin
      resp_valid[head] = bus.lc_valid_in;
      lc_ready         = bus.resp_ready_in[head];
    end
  end

  assign push = gnt_any && !bus.req_we_in[gnt_id];
  assign pop  = bus.lc_valid_in && lc_ready &&
                !fifo_empty;

  // Registered LC request stage and RR pointer.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      stg_valid <= 1'b0;
      stg_addr  <= '0;
      stg_value <= '0;
      stg_we    <= 1'b0;
      rr_ptr    <= '0;
    end else if (slot_free) begin
      stg_valid <= gnt_any;
      if (gnt_any) begin
        stg_addr  <= bus.req_addr_in[gnt_id*PADDR_BITS +:
                                     PADDR_BITS];
        stg_value <= bus.req_value_in[gnt_id*LINE_BITS +:
                                      LINE_BITS];
        stg_we    <= bus.req_we_in[gnt_id];
        rr_ptr    <= (gnt_id == LAST) ? '0 :
                     gnt_id + 1'b1;
      end
    end
  end

  // In-order ID FIFO of outstanding reads.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= gnt_id;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: count <= count + 1'b1;
        pop && !push: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end

  // Sticky flag for a response with nothing pending.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      err_q <= 1'b0;
    end else if (bus.lc_valid_in && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign bus.req_ready_out  = grant;
  assign bus.resp_valid_out = resp_valid;
  assign bus.resp_addr_out  = bus.lc_addr_in;
  assign bus.resp_value_out = bus.lc_value_in;
  assign bus.lc_ready_out   = lc_ready;
  assign bus.lc_valid_out   = stg_valid;
  assign bus.lc_addr_out    = stg_addr;
  assign bus.lc_value_out   = stg_value;
  assign bus.lc_we_out      = stg_we;
  assign bus.err_unexpected_resp_out = err_q;
endmodule

// File: tb/tb_lc_port_arbiter.sv
// Self-checking bench for lc_port_arbiter: vector
// table, corner sequences and a randomized model run.
module tb_lc_port_arbiter;
  localparam int AW = 22;
  localparam int LW = 512;
  localparam int NR = 2;
  localparam int OS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lc_port_arbiter_if #(
    .PADDR_BITS(AW), .LINE_BITS(LW), .N_REQ(NR)
  ) bus ();

  lc_port_arbiter #(
    .PADDR_BITS(AW), .LINE_BITS(LW),
    .N_REQ(NR), .OUTSTANDING(OS)
  ) dut (
    .clk_in(clk),
    .rst_N_in(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]    vin;
    logic [1:0]    we;
    logic          lrdy;
    logic          lcv;
    logic [1:0]    rrdy;
    logic [1:0]    e_rdy;
    logic          e_lcv;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [1:0]    e_rv;
    logic          e_lrdy;
    logic          e_err;
  } vec_t;

  vec_t tv[13];

  task automatic chk(string name, logic [LW-1:0] act,
                     logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic set_req(int c, logic [AW-1:0] a,
                         logic [LW-1:0] v);
    bus.req_addr_in[c*AW +: AW]  = a;
    bus.req_value_in[c*LW +: LW] = v;
  endtask

  task automatic drive(logic [1:0] vin, logic [1:0] we,
                       logic lrdy, logic lcv,
                       logic [1:0] rrdy);
    bus.req_valid_in  = vin;
    bus.req_we_in     = we;
    bus.lc_ready_in   = lrdy;
    bus.lc_valid_in   = lcv;
    bus.resp_ready_in = rrdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
    bus.req_addr_in  = '0;
    bus.req_value_in = '0;
    bus.lc_addr_in   = '0;
    bus.lc_value_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    v = '0;
    for (int j = 0; j < LW/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference model state
  bit             m_vld;
  logic [AW-1:0]  m_addr;
  logic [LW-1:0]  m_val;
  bit             m_we;
  int             m_rr;
  int             m_q[$];
  bit             m_err;
  logic [AW-1:0]  ra[NR];
  logic [LW-1:0]  rv[NR];

  initial begin
    logic [1:0]   vin, we, rrdy, e_rdy, e_rv;
    logic         lrdy, lcv, slot, e_lrdy;
    int           g;
    logic [LW-1:0] rsp;

    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lc_valid", LW'(bus.lc_valid_out), '0);
    chk("rst_req_ready", LW'(bus.req_ready_out), '0);
    chk("rst_resp_valid", LW'(bus.resp_valid_out), '0);
    chk("rst_err", LW'(bus.err_unexpected_resp_out), '0);
    chk("rst_lc_addr", LW'(bus.lc_addr_out), '0);
    chk("rst_lc_we", LW'(bus.lc_we_out), '0);

    // RR, FIFO full with write bypass, routing + stall
    tv[0]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b11, 2'b01,
               1'b0, 22'h0, 1'b0, 2'b00, 1'b1, 1'b0};
    tv[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b11, 2'b10,
               1'b1, 22'h00100, 1'b0, 2'b00, 1'b1, 1'b0};
    tv[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b11, 2'b01,
               1'b1, 22'h60300, 1'b0, 2'b00, 1'b1, 1'b0};
    tv[3]  = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b11, 2'b10,
               1'b1, 22'h00100, 1'b0, 2'b00, 1'b1, 1'b0};
    tv[4]  = '{2'b11, 2'b10, 1'b1, 1'b0, 2'b11, 2'b10,
               1'b1, 22'h60300, 1'b0, 2'b00, 1'b1, 1'b0};
    tv[5]  = '{2'b01, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00,
               1'b1, 22'h60300, 1'b1, 2'b01, 1'b1, 1'b0};
    tv[6]  = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b11, 2'b01,
               1'b0, 22'h0, 1'b0, 2'b00, 1'b1, 1'b0};
    tv[7]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b01, 2'b00,
               1'b1, 22'h00100, 1'b0, 2'b10, 1'b0, 1'b0};
    tv[8]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00,
               1'b0, 22'h0, 1'b0, 2'b10, 1'b1, 1'b0};
    tv[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00,
               1'b0, 22'h0, 1'b0, 2'b01, 1'b1, 1'b0};
    tv[10] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00,
               1'b0, 22'h0, 1'b0, 2'b10, 1'b1, 1'b0};
    tv[11] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b11, 2'b00,
               1'b0, 22'h0, 1'b0, 2'b01, 1'b1, 1'b0};
    tv[12] = '{2'b00, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00,
               1'b0, 22'h0, 1'b0, 2'b00, 1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #2;
      set_req(0, 22'h00100, {480'd0, 32'h1111_0000});
      set_req(1, 22'h60300, {480'd0, 32'h2222_0000});
      drive(tv[i].vin, tv[i].we, tv[i].lrdy, tv[i].lcv,
            tv[i].rrdy);
      rsp = {480'd0, 32'(32'hA0 + i)};
      bus.lc_value_in = rsp;
      bus.lc_addr_in  = AW'(32'h300 + i);
      @(negedge clk);
      chk($sformatf("tv%0d_req_ready", i),
          LW'(bus.req_ready_out), LW'(tv[i].e_rdy));
      chk($sformatf("tv%0d_lc_valid", i),
          LW'(bus.lc_valid_out), LW'(tv[i].e_lcv));
      if (tv[i].e_lcv) begin
        chk($sformatf("tv%0d_lc_addr", i),
            LW'(bus.lc_addr_out), LW'(tv[i].e_addr));
        chk($sformatf("tv%0d_lc_we", i),
            LW'(bus.lc_we_out), LW'(tv[i].e_we));
      end
      chk($sformatf("tv%0d_resp_valid", i),
          LW'(bus.resp_valid_out), LW'(tv[i].e_rv));
      chk($sformatf("tv%0d_lc_ready", i),
          LW'(bus.lc_ready_out), LW'(tv[i].e_lrdy));
      chk($sformatf("tv%0d_err", i),
          LW'(bus.err_unexpected_resp_out), LW'(tv[i].e_err));
      if (tv[i].e_rv != 2'b00) begin
        chk($sformatf("tv%0d_resp_value", i),
            bus.resp_value_out, rsp);
        chk($sformatf("tv%0d_resp_addr", i),
            LW'(bus.resp_addr_out), LW'(AW'(32'h300 + i)));
      end
    end

    // Backpressure on a writeback
    do_reset();
    @(posedge clk);
    #2;
    set_req(1, 22'h4040, {480'd0, 32'hC0C0C0C0});
    drive(2'b10, 2'b10, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    chk("bp_grant_wr", LW'(bus.req_ready_out), LW'(2'b10));
    @(posedge clk);
    #2;
    set_req(0, 22'h00100, '0);
    drive(2'b01, 2'b00, 1'b0, 1'b0, 2'b11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_lc_valid", LW'(bus.lc_valid_out), LW'(1'b1));
      chk("bp_lc_addr", LW'(bus.lc_addr_out), LW'(22'h4040));
      chk("bp_lc_we", LW'(bus.lc_we_out), LW'(1'b1));
      chk("bp_lc_value", bus.lc_value_out,
          {480'd0, 32'hC0C0C0C0});
      chk("bp_no_grant", LW'(bus.req_ready_out), '0);
      @(posedge clk);
      #2;
    end
    drive(2'b00, 2'b00, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    chk("bp_accept_valid", LW'(bus.lc_valid_out), LW'(1'b1));
    chk("bp_accept_addr", LW'(bus.lc_addr_out), LW'(22'h4040));
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("bp_drained", LW'(bus.lc_valid_out), '0);

    // Response with nothing pending (write left count at 0)
    @(posedge clk);
    #2;
    bus.lc_valid_in = 1'b1;
    @(negedge clk);
    chk("unexp_resp_valid", LW'(bus.resp_valid_out), '0);
    chk("unexp_lc_ready", LW'(bus.lc_ready_out), LW'(1'b1));
    chk("unexp_err_pre", LW'(bus.err_unexpected_resp_out), '0);
    @(posedge clk);
    #2;
    bus.lc_valid_in = 1'b0;
    @(negedge clk);
    chk("unexp_err_set", LW'(bus.err_unexpected_resp_out),
        LW'(1'b1));
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("unexp_err_sticky", LW'(bus.err_unexpected_resp_out),
        LW'(1'b1));

    // Reset with two reads outstanding
    @(posedge clk);
    #2;
    set_req(0, 22'h2000, '0);
    set_req(1, 22'h5000, '0);
    drive(2'b11, 2'b00, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    chk("mid_grant0", LW'(bus.req_ready_out), LW'(2'b01));
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("mid_grant1", LW'(bus.req_ready_out), LW'(2'b10));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_lc_valid", LW'(bus.lc_valid_out), '0);
    chk("mid_rst_err", LW'(bus.err_unexpected_resp_out), '0);
    chk("mid_rst_req_ready", LW'(bus.req_ready_out), '0);
    chk("mid_rst_resp_valid", LW'(bus.resp_valid_out), '0);
    drive(2'b00, 2'b00, 1'b1, 1'b0, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    bus.lc_valid_in = 1'b1;
    @(negedge clk);
    chk("post_rst_resp_valid", LW'(bus.resp_valid_out), '0);
    chk("post_rst_lc_ready", LW'(bus.lc_ready_out), LW'(1'b1));
    @(posedge clk);
    #2;
    bus.lc_valid_in = 1'b0;
    @(negedge clk);
    chk("post_rst_err", LW'(bus.err_unexpected_resp_out),
        LW'(1'b1));

    // Randomized run against the queue model
    do_reset();
    m_vld = 0; m_addr = '0; m_val = '0; m_we = 0;
    m_rr = 0; m_err = 0;
    m_q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NR; i++) begin
        ra[i] = AW'($urandom);
        rv[i] = rnd_line();
        set_req(i, ra[i], rv[i]);
      end
      vin  = 2'($urandom);
      we[0] = ($urandom_range(0, 9) < 3);
      we[1] = ($urandom_range(0, 9) < 3);
      lrdy = ($urandom_range(0, 3) != 0);
      rrdy[0] = ($urandom_range(0, 3) != 0);
      rrdy[1] = ($urandom_range(0, 3) != 0);
      if (m_q.size() > 0) lcv = $urandom_range(0, 1) == 1;
      else                lcv = $urandom_range(0, 99) == 0;
      drive(vin, we, lrdy, lcv, rrdy);
      rsp = rnd_line();
      bus.lc_value_in = rsp;
      bus.lc_addr_in  = AW'($urandom);

      slot = !m_vld || lrdy;
      g = -1;
      if (slot) begin
        for (int k = 0; k < NR; k++) begin
          int idx;
          idx = (m_rr + k) % NR;
          if (g < 0 && vin[idx] &&
              (we[idx] || m_q.size() < OS)) g = idx;
        end
      end
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      e_rv = '0;
      e_lrdy = 1'b1;
      if (m_q.size() > 0) begin
        e_rv[m_q[0]] = lcv;
        e_lrdy = rrdy[m_q[0]];
      end

      @(negedge clk);
      chk("rnd_req_ready", LW'(bus.req_ready_out), LW'(e_rdy));
      chk("rnd_lc_valid", LW'(bus.lc_valid_out), LW'(m_vld));
      if (m_vld) begin
        chk("rnd_lc_addr", LW'(bus.lc_addr_out), LW'(m_addr));
        chk("rnd_lc_we", LW'(bus.lc_we_out), LW'(m_we));
        chk("rnd_lc_value", bus.lc_value_out, m_val);
      end
      chk("rnd_resp_valid", LW'(bus.resp_valid_out), LW'(e_rv));
      chk("rnd_lc_ready", LW'(bus.lc_ready_out), LW'(e_lrdy));
      chk("rnd_err", LW'(bus.err_unexpected_resp_out),
          LW'(m_err));
      if (e_rv != 2'b00) begin
        chk("rnd_resp_value", bus.resp_value_out, rsp);
      end

      if (lcv && m_q.size() == 0) m_err = 1;
      if (lcv && e_lrdy && m_q.size() > 0) void'(m_q.pop_front());
      if (slot) begin
        m_vld = (g >= 0);
        if (g >= 0) begin
          m_addr = ra[g];
          m_val  = rv[g];
          m_we   = we[g];
          if (!we[g]) m_q.push_back(g);
          m_rr = (g + 1) % NR;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
